// File: rtl/u_bam8_acc_pkg.sv
// Shared definitions for the approximate-multiplier beat accumulator.
package u_bam8_acc_pkg;

    // Width of one product beat from the upstream 8x8 array multiplier.
    localparam int PROD_W    = 16;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_CNT_W = 8;

    // ACC: collecting beats of a frame; HOLD: presenting the finished frame.
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/u_bam8_acc_satadd.sv
// Combinational saturating adder: acc + zero-extended prod, clamped to all-ones.
module u_bam8_acc_satadd
    import u_bam8_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    // One extra bit keeps the carry so overflow is exact before clamping.
    logic [ACC_W:0] wide;

    // Add at ACC_W+1 bits, then clamp on carry-out.
    always_comb begin
        wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        ovf  = wide[ACC_W];
        sum  = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/u_bam8_acc.sv
// Frame accumulator for product beats: saturating sum, saturating beat count,
// and a one-entry result hold with valid/ready handshake.
module u_bam8_acc
    import u_bam8_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               retire;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic               acc_ovf;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               sat;
    logic               sat_nxt;

    u_bam8_acc_satadd #(
        .ACC_W (ACC_W)
    ) u_satadd (
        .acc  (acc),
        .prod (in_prod),
        .sum  (acc_sum),
        .ovf  (acc_ovf)
    );

    // Beat counter sticks at all-ones; sat is sticky across the frame.
    always_comb begin
        cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
        sat_nxt = sat | acc_ovf;
    end

    // Next-state and handshake decode; ready/valid depend on state only.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        retire    = 1'b0;
        case (state)
            ST_ACC: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && in_last) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                retire    = out_ready;
                if (out_ready) begin
                    state_nxt = ST_ACC;
                end
            end
            default: state_nxt = ST_ACC;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator, counter, sat flag and the registered frame result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
            out_sum <= '0;
            out_cnt <= '0;
            out_sat <= 1'b0;
        end else if (retire) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt_nxt;
            sat <= sat_nxt;
            if (in_last) begin
                out_sum <= acc_sum;
                out_cnt <= cnt_nxt;
                out_sat <= sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_u_bam8_acc.sv
// Directed and randomized checks of u_bam8_acc at default widths (a) and
// at ACC_W=18, CNT_W=4 (b), both fed the same beat stream.
module tb_u_bam8_acc;

    localparam longint A_MAX_SUM = (64'd1 << 24) - 1;
    localparam longint B_MAX_SUM = (64'd1 << 18) - 1;
    localparam int     A_MAX_CNT = 255;
    localparam int     B_MAX_CNT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_prod = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_sat;
    logic [23:0] a_out_sum;
    logic [7:0]  a_out_cnt;
    logic        b_in_ready, b_out_valid, b_out_sat;
    logic [17:0] b_out_sum;
    logic [3:0]  b_out_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    u_bam8_acc dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (a_in_ready),
        .out_sum   (a_out_sum),
        .out_cnt   (a_out_cnt),
        .out_sat   (a_out_sat),
        .out_valid (a_out_valid),
        .out_ready (out_ready)
    );

    u_bam8_acc #(
        .ACC_W (18),
        .CNT_W (4)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (b_in_ready),
        .out_sum   (b_out_sum),
        .out_cnt   (b_out_cnt),
        .out_sat   (b_out_sat),
        .out_valid (b_out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] p, input logic last);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_frame(input string tag,
                             input logic [63:0] as, input logic [63:0] ac, input logic [63:0] at,
                             input logic [63:0] bs, input logic [63:0] bc, input logic [63:0] bt);
        chk({tag, ".a_valid"}, 64'(a_out_valid), 64'd1);
        chk({tag, ".a_sum"},   64'(a_out_sum),   as);
        chk({tag, ".a_cnt"},   64'(a_out_cnt),   ac);
        chk({tag, ".a_sat"},   64'(a_out_sat),   at);
        chk({tag, ".b_valid"}, 64'(b_out_valid), 64'd1);
        chk({tag, ".b_sum"},   64'(b_out_sum),   bs);
        chk({tag, ".b_cnt"},   64'(b_out_cnt),   bc);
        chk({tag, ".b_sat"},   64'(b_out_sat),   bt);
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        tick();
        chk({tag, ".retire_a_valid"}, 64'(a_out_valid), 64'd0);
        chk({tag, ".retire_b_valid"}, 64'(b_out_valid), 64'd0);
        chk({tag, ".retire_a_ready"}, 64'(a_in_ready),  64'd1);
    endtask

    // Random-phase model state
    int          beats_done;
    int          cyc;
    int          m_hold;
    longint      raw_sum;
    int          raw_cnt;
    longint      ea_sum, eb_sum;
    int          ea_cnt, eb_cnt;
    logic        ea_sat, eb_sat;
    logic        r_valid, r_last, r_ready;
    logic [15:0] r_prod;

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst.a_valid", 64'(a_out_valid), 64'd0);
        chk("rst.a_ready", 64'(a_in_ready),  64'd1);
        chk("rst.a_sum",   64'(a_out_sum),   64'd0);
        chk("rst.a_cnt",   64'(a_out_cnt),   64'd0);
        chk("rst.b_sat",   64'(b_out_sat),   64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // ---------------- three beats of 0x2000, first beat on first edge ----------------
        beat(16'h2000, 1'b0);
        beat(16'h2000, 1'b0);
        beat(16'h2000, 1'b1);
        chk_frame("f3", 24576, 3, 0, 24576, 3, 0);
        retire("f3");
        chk("f3.keep_sum", 64'(a_out_sum), 64'd24576);

        // ---------------- five beats of 0xFFFF: b saturates, a does not ----------------
        for (int i = 0; i < 5; i++) beat(16'hFFFF, i == 4);
        chk_frame("ff5", 327675, 5, 0, 262143, 5, 1);
        retire("ff5");
        beat(16'h0001, 1'b1);
        chk_frame("one", 1, 1, 0, 1, 1, 0);
        retire("one");

        // ---------------- zero-valued beat still counts ----------------
        beat(16'h0000, 1'b0);
        beat(16'h0010, 1'b1);
        chk_frame("zero", 16, 2, 0, 16, 2, 0);
        retire("zero");

        // ---------------- backpressure in HOLD with in_valid high ----------------
        out_ready = 1'b0;
        beat(16'h0100, 1'b0);
        beat(16'h0200, 1'b1);
        chk_frame("bp", 768, 2, 0, 768, 2, 0);
        in_valid = 1'b1;
        in_prod  = 16'h7777;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp.a_ready", 64'(a_in_ready), 64'd0);
            chk("bp.b_ready", 64'(b_in_ready), 64'd0);
            chk_frame("bp.hold", 768, 2, 0, 768, 2, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp.bubble_valid", 64'(a_out_valid), 64'd0);
        chk("bp.bubble_ready", 64'(a_in_ready),  64'd1);
        in_prod = 16'h0005;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_frame("bp.next", 5, 1, 0, 5, 1, 0);
        retire("bp.next");

        // ---------------- count saturation ----------------
        for (int i = 0; i < 20; i++) beat(16'h0001, i == 19);
        chk_frame("c20", 20, 20, 0, 20, 15, 0);
        retire("c20");
        for (int i = 0; i < 260; i++) beat(16'hFFFF, i == 259);
        chk_frame("big", A_MAX_SUM, A_MAX_CNT, 1, B_MAX_SUM, B_MAX_CNT, 1);
        retire("big");

        // ---------------- reset mid-frame and in HOLD ----------------
        beat(16'h0200, 1'b0);
        beat(16'h0200, 1'b0);
        chk("mid.no_valid", 64'(a_out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid.rst_sum", 64'(a_out_sum), 64'd0);
        chk("mid.rst_cnt", 64'(b_out_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid.no_valid2", 64'(a_out_valid), 64'd0);
        beat(16'h0200, 1'b0);
        beat(16'h0200, 1'b1);
        chk_frame("mid", 1024, 2, 0, 1024, 2, 0);
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("hold.rst_valid", 64'(a_out_valid), 64'd0);
        chk("hold.rst_ready", 64'(b_in_ready),  64'd1);
        chk("hold.rst_sum",   64'(b_out_sum),   64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- randomized traffic vs. frame-level model ----------------
        m_hold     = 0;
        raw_sum    = 0;
        raw_cnt    = 0;
        beats_done = 0;
        cyc        = 0;
        ea_sum = 0; eb_sum = 0; ea_cnt = 0; eb_cnt = 0; ea_sat = 0; eb_sat = 0;
        while (beats_done < 10000 && cyc < 60000) begin
            r_valid = ($urandom_range(0, 3) != 0);
            r_last  = ($urandom_range(0, 9) == 0);
            r_ready = ($urandom_range(0, 2) != 0);
            r_prod  = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            in_valid  = r_valid;
            in_last   = r_last;
            in_prod   = r_prod;
            out_ready = r_ready;
            chk("rnd.a_ready", 64'(a_in_ready), 64'(m_hold == 0));
            chk("rnd.b_ready", 64'(b_in_ready), 64'(m_hold == 0));
            if (m_hold == 0 && r_valid) begin
                raw_sum += longint'(r_prod);
                raw_cnt++;
                beats_done++;
                if (r_last) begin
                    ea_sum = (raw_sum > A_MAX_SUM) ? A_MAX_SUM : raw_sum;
                    eb_sum = (raw_sum > B_MAX_SUM) ? B_MAX_SUM : raw_sum;
                    ea_cnt = (raw_cnt > A_MAX_CNT) ? A_MAX_CNT : raw_cnt;
                    eb_cnt = (raw_cnt > B_MAX_CNT) ? B_MAX_CNT : raw_cnt;
                    ea_sat = (raw_sum > A_MAX_SUM);
                    eb_sat = (raw_sum > B_MAX_SUM);
                    m_hold = 1;
                end
            end else if (m_hold != 0 && r_ready) begin
                m_hold  = 0;
                raw_sum = 0;
                raw_cnt = 0;
            end
            tick();
            cyc++;
            if (m_hold != 0) begin
                chk_frame("rnd", ea_sum, ea_cnt, ea_sat, eb_sum, eb_cnt, eb_sat);
            end else begin
                chk("rnd.a_valid", 64'(a_out_valid), 64'd0);
                chk("rnd.b_valid", 64'(b_out_valid), 64'd0);
            end
        end
        chk("rnd.beat_budget", 64'(beats_done >= 10000), 64'd1);
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
